uart_transmitter: RTL and testbench

- UART transmit path, the counterpart of the receive-side serializer/shifter.
- Accepts one parallel byte on a write strobe and drives it out on TxD as a frame: start bit, DATA_BITS data bits LSB first, optional even parity, one stop bit.
- Bit timing comes from an external oversampling tick: one bit period = OVERSAMPLE ticks.
- Sits between the host-side write interface and the serial pin, sharing the baud generator with the receiver.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_tx_shifter.sv | 58 +++++
 rtl/uart_transmitter.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Purpose:
//   Definitions shared by the UART transmit and receive paths:
//     - FSM state encoding. Both directions use the same encoding, so a
//       debugger or logic analyser decodes either FSM identically.
//     - Default frame geometry (DATA_BITS, OVERSAMPLE).
//     - The idle (marking) level of the serial line.
//     - A small width helper for counters and indices.
//
// Ports: none (package).
//
// Configuration:
//   ST_PARITY is always present in the encoding, even when the transmitter is
//   built without UART_TX_PARITY_EN. This keeps the encoding stable across
//   builds and across the receive/transmit pair.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DATA_BITS_DEFAULT  = 8;
    localparam int   OVERSAMPLE_DEFAULT = 16;
    localparam logic IDLE_LEVEL         = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Width needed to count 0..v-1. Never returns less than one bit, so
    // degenerate parameter values still give legal vector declarations.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_shifter.sv
// -----------------------------------------------------------------------------
// uart_tx_shifter
//
// Purpose:
//   Parallel-load, shift-right serializer for the UART transmit path. It is
//   the mirror of the receive shifter: the receiver shifts bits in at the
//   MSB end, and this block shifts them out at the LSB end.
//
// Ports:
//   clk      in   system clock, posedge
//   reset    in   synchronous, active-low; clears the register
//   i_load   in   load i_data (takes priority over i_shift)
//   i_shift  in   shift right by one, zero-filling the MSB
//   i_data   in   [WIDTH-1:0] parallel word to load
//   o_bit0   out  current serial bit (register bit 0)
//   o_bit1   out  bit that becomes bit 0 after the next shift. The
//                 transmitter uses it to register TxD on the same edge as
//                 the shift.
// -----------------------------------------------------------------------------
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int WIDTH = DATA_BITS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_bit0,
    output logic             o_bit1
);

    logic [WIDTH-1:0] r_shift;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (i_load) begin
            r_shift <= i_data;
        end else if (i_shift) begin
            r_shift <= r_shift >> 1;
        end
    end

    assign o_bit0 = r_shift[0];

    // A one-bit shifter has no look-ahead bit. After a shift only the
    // zero fill is left.
    generate
        if (WIDTH > 1) begin : g_lookahead
            assign o_bit1 = r_shift[1];
        end else begin : g_no_lookahead
            assign o_bit1 = 1'b0;
        end
    endgenerate

endmodule : uart_tx_shifter

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//
// Purpose:
//   UART transmit path. It accepts one parallel word on a write strobe and
//   sends it on TxD as one frame:
//       start (0), DATA_BITS data bits LSB first, [even parity], stop (1).
//   One bit period is OVERSAMPLE ticks of Tx_sample_enable. The tick comes
//   from the baud generator that is shared with the receiver.
//
// Parameters:
//   DATA_BITS   data bits per frame (default 8)
//   OVERSAMPLE  Tx_sample_enable ticks per bit period; must be a power of two
//               (default 16)
//
// Ports:
//   clk               in   system clock, posedge
//   reset             in   synchronous, active-low. Aborts any frame in
//                          progress on the same edge.
//   Tx_EN             in   a new frame is accepted only while this is high
//   Tx_WR             in   single-cycle write strobe
//   Tx_DATA           in   [DATA_BITS-1:0] word. Sampled only on an accepted
//                          write.
//   Tx_sample_enable  in   baud oversample tick, one clk wide
//   TxD               out  registered serial line; idles at 1
//   Tx_BUSY           out  high while a frame is in progress
//
// Configuration:
//   UART_TX_PARITY_EN  When defined, the PARITY state and an even-parity bit
//                      between the last data bit and the stop bit are
//                      included. When undefined, frames are 8N1-style and no
//                      parity logic is built.
// -----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Tx_EN,
    input  logic                 Tx_WR,
    input  logic [DATA_BITS-1:0] Tx_DATA,
    input  logic                 Tx_sample_enable,
    output logic                 TxD,
    output logic                 Tx_BUSY
);

    localparam int CNT_W  = clog2_min1(OVERSAMPLE);
    localparam int BIDX_W = clog2_min1(DATA_BITS);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(DATA_BITS - 1);

    // ---------------------------------------------------------------------
    // Registers and combinational nets
    // ---------------------------------------------------------------------
    uart_state_t       r_state;
    uart_state_t       w_state_next;
    logic [CNT_W-1:0]  r_tick_cnt;
    logic [BIDX_W-1:0] r_bit_idx;
    logic              r_txd;
    logic              r_busy;

    logic w_accept;     // write taken in this cycle
    logic w_bit_end;    // this tick ends the current bit period
    logic w_last_data;  // the data bit now on the line is the final one
    logic w_shift;      // advance the serializer
    logic w_sh_bit0;
    logic w_sh_bit1;
    logic w_data_bit;   // data bit that will be on the line after this edge
    logic w_txd_next;

`ifdef UART_TX_PARITY_EN
    // Parity is taken from the word as written. It is latched here because
    // the shifter has consumed the word by the time the parity bit is sent.
    logic r_parity;
`endif

    // ---------------------------------------------------------------------
    // Event decode
    // ---------------------------------------------------------------------
    assign w_accept    = (r_state == ST_IDLE) && Tx_WR && Tx_EN;
    assign w_bit_end   = (r_state != ST_IDLE) && Tx_sample_enable
                         && (r_tick_cnt == TICK_LAST);
    assign w_last_data = (r_bit_idx == BIDX_LAST);
    assign w_shift     = (r_state == ST_DATA) && w_bit_end;

    // ---------------------------------------------------------------------
    // Serializer
    // ---------------------------------------------------------------------
    uart_tx_shifter #(
        .WIDTH (DATA_BITS)
    ) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_data  (Tx_DATA),
        .o_bit0  (w_sh_bit0),
        .o_bit1  (w_sh_bit1)
    );

    // On the edge that shifts, the next bit on the line is the current
    // bit 1. On the START->DATA edge no shift occurs, so bit 0 goes out.
    assign w_data_bit = w_shift ? w_sh_bit1 : w_sh_bit0;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_bit_end && w_last_data) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    w_state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Line level for the state being entered. TxD is registered from this
    // value, so the line changes on the same edge as the state and never
    // glitches.
    // ---------------------------------------------------------------------
    always_comb begin
        w_txd_next = IDLE_LEVEL;
        case (w_state_next)
            ST_START:  w_txd_next = 1'b0;
            ST_DATA:   w_txd_next = w_data_bit;
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_txd_next = r_parity;
`endif
            default:   w_txd_next = IDLE_LEVEL;
        endcase
    end

    // ---------------------------------------------------------------------
    // Tick counter, bit index, and registered outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_txd      <= IDLE_LEVEL;
            r_busy     <= 1'b0;
        end else begin
            r_txd  <= w_txd_next;
            r_busy <= (w_state_next != ST_IDLE);

            // A tick that arrives in the accept cycle is not counted, so
            // START always lasts a full OVERSAMPLE ticks.
            if (w_accept) begin
                r_tick_cnt <= '0;
            end else if ((r_state != ST_IDLE) && Tx_sample_enable) begin
                r_tick_cnt <= w_bit_end ? '0 : r_tick_cnt + 1'b1;
            end

            if (w_accept) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= w_last_data ? '0 : r_bit_idx + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^Tx_DATA;
        end
    end
`endif

    assign TxD     = r_txd;
    assign Tx_BUSY = r_busy;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//
// Self-checking bench for uart_transmitter. A frame is modelled as a list of
// line levels (start, data LSB first, optional parity, stop). The expected
// TxD after the n-th tick since the accept is the entry at index n/OVERSAMPLE
// of that list. Tx_BUSY is expected high while n < frame length.
// Build with UART_TX_PARITY_EN defined to exercise the parity frame.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int DB = 8;
    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = (DB + 2 + PAR) * OS;

    logic          clk;
    logic          reset;
    logic          Tx_EN;
    logic          Tx_WR;
    logic [DB-1:0] Tx_DATA;
    logic          Tx_sample_enable;
    logic          TxD;
    logic          Tx_BUSY;

    int n_checks = 0;
    int n_errors = 0;

    logic model_bits[$];
    logic obs_txd[$];
    logic obs_busy[$];

    uart_transmitter dut (
        .clk              (clk),
        .reset            (reset),
        .Tx_EN            (Tx_EN),
        .Tx_WR            (Tx_WR),
        .Tx_DATA          (Tx_DATA),
        .Tx_sample_enable (Tx_sample_enable),
        .TxD              (TxD),
        .Tx_BUSY          (Tx_BUSY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ----------------------------- reference model -------------------------
    function automatic void model_frame(input logic [DB-1:0] d);
        model_bits.delete();
        model_bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) model_bits.push_back(d[i]);
        if (PAR != 0) model_bits.push_back(^d);
        model_bits.push_back(1'b1);
    endfunction

    function automatic logic model_txd(input int n);
        return (n < FRAME_TICKS) ? model_bits[n / OS] : 1'b1;
    endfunction

    function automatic logic model_busy(input int n);
        return (n < FRAME_TICKS);
    endfunction

    // ----------------------------- stimulus --------------------------------
    // All tasks start and end at a negedge.
    task automatic do_write(input logic [DB-1:0] d, input logic en, input logic tick);
        Tx_DATA          = d;
        Tx_EN            = en;
        Tx_WR            = 1'b1;
        Tx_sample_enable = tick;
        @(negedge clk);
        Tx_WR            = 1'b0;
        Tx_sample_enable = 1'b0;
        Tx_DATA          = DB'($urandom);
    endtask

    // Issues n ticks, one every 'gap' clocks. TxD and Tx_BUSY are captured
    // after each tick edge.
    task automatic run_ticks(input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            repeat (gap - 1) @(negedge clk);
            Tx_sample_enable = 1'b1;
            @(negedge clk);
            Tx_sample_enable = 1'b0;
            obs_txd.push_back(TxD);
            obs_busy.push_back(Tx_BUSY);
        end
    endtask

    // ----------------------------- tests -----------------------------------
    task automatic test_reset();
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            Tx_EN            = 1'b1;
            Tx_WR            = 1'(($urandom & 1));
            Tx_DATA          = DB'($urandom);
            Tx_sample_enable = 1'(($urandom & 1));
            @(negedge clk);
            n_checks++;
            if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_hold cyc=%0d got TxD=%b busy=%b exp TxD=1 busy=0", c, TxD, Tx_BUSY);
            end
        end
        Tx_WR = 1'b0; Tx_sample_enable = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release got TxD=%b busy=%b exp TxD=1 busy=0", TxD, Tx_BUSY);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        logic [DB-1:0] d;
        int gap;
        for (int f = 0; f < 4; f++) begin
            d   = (f == 0) ? DB'(8'h55) : DB'($urandom);
            gap = (f == 0) ? 4 : int'($urandom_range(1, 4));
            model_frame(d);
            do_write(d, 1'b1, 1'b0);
            n_checks++;
            if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) begin
                n_errors++;
                $display("FAIL basic_accept byte=%02h got TxD=%b busy=%b exp TxD=0 busy=1", d, TxD, Tx_BUSY);
            end
            obs_txd.delete(); obs_busy.delete();
            run_ticks(FRAME_TICKS + 8, gap);
            for (int k = 0; k < obs_txd.size(); k++) begin
                n_checks++;
                if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                    n_errors++;
                    $display("FAIL basic_frame byte=%02h tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                             d, k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
                end
            end
            $display("frame byte=%02h gap=%0d ticks=%0d", d, gap, FRAME_TICKS);
        end
    endtask

    task automatic test_parity();
`ifdef UART_TX_PARITY_EN
        logic [DB-1:0] d;
        logic          exp_par;
        for (int f = 0; f < 2; f++) begin
            d       = (f == 0) ? DB'(8'h07) : DB'(8'h55);
            exp_par = (f == 0) ? 1'b1 : 1'b0;
            model_frame(d);
            do_write(d, 1'b1, 1'b0);
            obs_txd.delete(); obs_busy.delete();
            run_ticks(FRAME_TICKS + 4, 2);
            for (int k = 0; k < obs_txd.size(); k++) begin
                n_checks++;
                if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                    n_errors++;
                    $display("FAIL parity_frame byte=%02h tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                             d, k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
                end
            end
            // Middle of the parity bit period.
            n_checks++;
            if (obs_txd[(DB + 1) * OS + OS / 2] !== exp_par) begin
                n_errors++;
                $display("FAIL parity_bit byte=%02h got %b exp %b", d, obs_txd[(DB + 1) * OS + OS / 2], exp_par);
            end
            $display("parity frame byte=%02h parity=%b", d, exp_par);
        end
`else
        $display("test_parity skipped (parity not built)");
`endif
    endtask

    task automatic test_ignored();
        logic [DB-1:0] d;
        d = DB'($urandom);
        model_frame(d);
        do_write(d, 1'b1, 1'b0);
        obs_txd.delete(); obs_busy.delete();
        run_ticks(50, 2);
        do_write(DB'(8'hFF), 1'b1, 1'b0);   // ignored while busy
        Tx_EN = 1'b0;                      // mid-frame disable must not abort
        run_ticks(FRAME_TICKS - 50 + 20, 2);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                n_errors++;
                $display("FAIL ignored_busy byte=%02h tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                         d, k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
            end
        end
        $display("frame byte=%02h with write ff while busy, Tx_EN dropped mid-frame", d);
        do_write(DB'(8'h12), 1'b0, 1'b0);   // ignored: Tx_EN low
        n_checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL ignored_en_accept got TxD=%b busy=%b exp TxD=1 busy=0", TxD, Tx_BUSY);
        end
        obs_txd.delete(); obs_busy.delete();
        run_ticks(40, 3);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== 1'b1 || obs_busy[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL ignored_en_idle tick=%0d got TxD=%b busy=%b exp TxD=1 busy=0", k + 1, obs_txd[k], obs_busy[k]);
            end
        end
        Tx_EN = 1'b1;
        $display("write 12 with Tx_EN=0 ignored");
    endtask

    task automatic test_reset_mid_frame();
        model_frame(DB'(8'hA5));
        do_write(DB'(8'hA5), 1'b1, 1'b0);
        obs_txd.delete(); obs_busy.delete();
        run_ticks(OS + 3 * OS + 5, 2);     // inside data bit 3
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== model_txd(k + 1)) begin
                n_errors++;
                $display("FAIL rst_prefix tick=%0d got TxD=%b exp %b", k + 1, obs_txd[k], model_txd(k + 1));
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_abort got TxD=%b busy=%b exp TxD=1 busy=0", TxD, Tx_BUSY);
        end
        reset = 1'b1;
        obs_txd.delete(); obs_busy.delete();
        run_ticks(3 * OS, 2);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== 1'b1 || obs_busy[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL rst_idle tick=%0d got TxD=%b busy=%b exp TxD=1 busy=0", k + 1, obs_txd[k], obs_busy[k]);
            end
        end
        model_frame(DB'(8'h3C));
        do_write(DB'(8'h3C), 1'b1, 1'b0);
        obs_txd.delete(); obs_busy.delete();
        run_ticks(FRAME_TICKS + 4, 2);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                n_errors++;
                $display("FAIL rst_next_frame tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                         k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
            end
        end
        $display("reset mid-frame a5, then frame 3c");
    endtask

    task automatic test_back_to_back();
        model_frame(DB'(8'h81));
        do_write(DB'(8'h81), 1'b1, 1'b0);
        obs_txd.delete(); obs_busy.delete();
        run_ticks(FRAME_TICKS, 3);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                n_errors++;
                $display("FAIL b2b_first tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                         k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
            end
        end
        // First cycle with Tx_BUSY low; the write coincides with a tick.
        do_write(DB'(8'h18), 1'b1, 1'b1);
        n_checks++;
        if (TxD !== 1'b0 || Tx_BUSY !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_accept got TxD=%b busy=%b exp TxD=0 busy=1", TxD, Tx_BUSY);
        end
        model_frame(DB'(8'h18));
        obs_txd.delete(); obs_busy.delete();
        run_ticks(FRAME_TICKS + 4, 3);
        for (int k = 0; k < obs_txd.size(); k++) begin
            n_checks++;
            if (obs_txd[k] !== model_txd(k + 1) || obs_busy[k] !== model_busy(k + 1)) begin
                n_errors++;
                $display("FAIL b2b_second tick=%0d got TxD=%b busy=%b exp TxD=%b busy=%b",
                         k + 1, obs_txd[k], obs_busy[k], model_txd(k + 1), model_busy(k + 1));
            end
        end
        $display("back-to-back frames 81 then 18");
    endtask

    initial begin
        reset            = 1'b0;
        Tx_EN            = 1'b0;
        Tx_WR            = 1'b0;
        Tx_DATA          = '0;
        Tx_sample_enable = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_ignored();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_uart_transmitter
